ssd_scan_controller: RTL and testbench

SSD_SCAN_CONTROLLER -- requirements
Module: ssd_scan_controller

---
 rtl/ssd_scan_controller.sv | 136 +++++++++++++
 tb/tb_ssd_scan_controller.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_controller.sv
// Four-digit multiplexed seven-segment scan controller with a handshaked shadow
// register, leading-zero blanking and registered active-low anode/segment outputs.
module ssd_scan_controller #(
   parameter int unsigned REFRESH_DIV   = 100000,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] number,
   input  logic        load,
   output logic        load_ack,
   input  logic        enable,
   output logic [3:0]  Anode_Activate,
   output logic [6:0]  SSD_LED_out,
   output logic [1:0]  digit_sel,
   output logic        frame_done
);

   localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [15:0]     shadow_q, shadow_d;
   logic            ack_q, ack_d;
   logic            frame_q, frame_d;
   logic [3:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;

   logic            tick;
   logic            capture;
   logic            blank;
   logic [3:0]      nib;

   function automatic logic [6:0] seg_lut(input logic [3:0] val);
      logic [6:0] code;
      case (val)
         4'h0:    code = 7'b0000001;
         4'h1:    code = 7'b1001111;
         4'h2:    code = 7'b0010010;
         4'h3:    code = 7'b0000110;
         4'h4:    code = 7'b1001100;
         4'h5:    code = 7'b0100100;
         4'h6:    code = 7'b0100000;
         4'h7:    code = 7'b0001111;
         4'h8:    code = 7'b0000000;
         4'h9:    code = 7'b0000100;
         4'hA:    code = 7'b0001000;
         4'hB:    code = 7'b1100000;
         4'hC:    code = 7'b0110001;
         4'hD:    code = 7'b1000010;
         4'hE:    code = 7'b0110000;
         default: code = 7'b0111000;
      endcase
      return code;
   endfunction

   // Prescaler, digit index and shadow capture.
   always_comb begin
      tick     = enable && (cnt_q == CntMax);
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      frame_d  = 1'b0;
      capture  = 1'b0;

      if (!enable) begin
         cnt_d = '0;
         idx_d = '0;
      end else if (tick) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         cnt_d = cnt_q + CntW'(1);
      end

      frame_d = tick && (idx_q == 2'd3);

      // While disabled, the ack guard keeps load_ack a single-cycle pulse.
      if (enable) begin
         capture = tick && (idx_q == 2'd3) && load;
      end else begin
         capture = load && !ack_q;
      end

      shadow_d = capture ? number : shadow_q;
      ack_d    = capture;
   end

   // Output decode from the registered index and shadow value.
   always_comb begin
      nib   = shadow_q[{idx_q, 2'b00} +: 4];
      blank = 1'b0;
      if (BLANK_LEADING) begin
         case (idx_q)
            2'd1:    blank = (shadow_q[15:4] == 12'h000);
            2'd2:    blank = (shadow_q[15:8] == 8'h00);
            2'd3:    blank = (shadow_q[15:12] == 4'h0);
            default: blank = 1'b0;
         endcase
      end

      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      if (enable && !blank) begin
         an_d  = ~(4'b0001 << idx_q);
         seg_d = seg_lut(nib);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         ack_q    <= 1'b0;
         frame_q  <= 1'b0;
         an_q     <= 4'b1111;
         seg_q    <= 7'b1111111;
      end else begin
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         ack_q    <= ack_d;
         frame_q  <= frame_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign load_ack       = ack_q;
   assign frame_done     = frame_q;
   assign digit_sel      = idx_q;
   assign Anode_Activate = an_q;
   assign SSD_LED_out    = seg_q;

endmodule

// File: tb/tb_ssd_scan_controller.sv
// Directed bench for ssd_scan_controller at REFRESH_DIV=4 with leading-zero blanking.
module tb_ssd_scan_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] number;
   logic        load;
   logic        load_ack;
   logic        enable;
   logic [3:0]  Anode_Activate;
   logic [6:0]  SSD_LED_out;
   logic [1:0]  digit_sel;
   logic        frame_done;

   int errs   = 0;
   int checks = 0;

   ssd_scan_controller #(
      .REFRESH_DIV   (4),
      .BLANK_LEADING (1'b1)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .number         (number),
      .load           (load),
      .load_ack       (load_ack),
      .enable         (enable),
      .Anode_Activate (Anode_Activate),
      .SSD_LED_out    (SSD_LED_out),
      .digit_sel      (digit_sel),
      .frame_done     (frame_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_blank(input string tag);
      check_eq({tag, "_an"}, 32'(Anode_Activate), 32'hF);
      check_eq({tag, "_seg"}, 32'(SSD_LED_out), 32'h7F);
   endtask

   // Steps one 16-cycle frame starting right after a 3->0 wrap edge.
   task automatic check_frame(input string tag, input logic [15:0] an_all,
                              input logic [27:0] seg_all);
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 4; c++) begin
            step();
            check_eq({tag, "_an"}, 32'(Anode_Activate), 32'(an_all[s*4 +: 4]));
            check_eq({tag, "_seg"}, 32'(SSD_LED_out), 32'(seg_all[s*7 +: 7]));
            check_eq({tag, "_sel"}, 32'(digit_sel), (c < 3) ? 32'(s) : 32'((s + 1) % 4));
            check_eq({tag, "_fd"}, 32'(frame_done), (s == 3 && c == 3) ? 32'd1 : 32'd0);
            check_eq({tag, "_ack"}, 32'(load_ack), 32'd0);
         end
      end
   endtask

   // Presents a value right after a wrap; the ack must land on the next wrap edge.
   task automatic do_load(input string tag, input logic [15:0] val);
      int n;
      n      = 0;
      number = val;
      load   = 1'b1;
      while (n < 40) begin
         step();
         n++;
         if (load_ack) break;
      end
      check_eq({tag, "_ackcyc"}, 32'(n), 32'd16);
      check_eq({tag, "_ackfd"}, 32'(frame_done), 32'd1);
      check_eq({tag, "_acksel"}, 32'(digit_sel), 32'd0);
      load = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      load   = 1'b0;
      number = 16'h0000;
      step();
      step();
      check_blank("rst");
      check_eq("rst_ack", 32'(load_ack), 32'd0);
      check_eq("rst_fd", 32'(frame_done), 32'd0);
      check_eq("rst_sel", 32'(digit_sel), 32'd0);

      // First load after reset: shadow still 0 during the first frame.
      reset  = 1'b0;
      enable = 1'b1;
      do_load("ld12af", 16'h12AF);
      check_frame("f12af", 16'b0111_1011_1101_1110,
                  {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000});

      do_load("ld0005", 16'h0005);
      check_frame("f0005", 16'b1111_1111_1111_1110,
                  {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100});

      number = 16'hFFFF;
      check_frame("fhold", 16'b1111_1111_1111_1110,
                  {7'b1111111, 7'b1111111, 7'b1111111, 7'b0100100});

      do_load("ld0000", 16'h0000);
      check_frame("f0000", 16'b1111_1111_1111_1110,
                  {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001});

      // Disabled load path.
      enable = 1'b0;
      load   = 1'b1;
      number = 16'hBEEF;
      step();
      check_eq("dis_ack", 32'(load_ack), 32'd1);
      check_eq("dis_sel", 32'(digit_sel), 32'd0);
      check_blank("dis");
      load = 1'b0;
      step();
      check_eq("dis_ack2", 32'(load_ack), 32'd0);
      step();
      check_blank("dis2");
      enable = 1'b1;
      check_frame("fbeef", 16'b0111_1011_1101_1110,
                  {7'b1100000, 7'b0110000, 7'b0110000, 7'b0111000});

      // Reset mid-frame at index 2 with a load pending.
      number = 16'h1234;
      load   = 1'b1;
      repeat (9) step();
      check_eq("pre_sel", 32'(digit_sel), 32'd2);
      check_eq("pre_ack", 32'(load_ack), 32'd0);
      #2 reset = 1'b1;
      #1;
      check_blank("arst");
      check_eq("arst_sel", 32'(digit_sel), 32'd0);
      check_eq("arst_ack", 32'(load_ack), 32'd0);
      step();
      step();
      load  = 1'b0;
      reset = 1'b0;
      check_frame("fpost", 16'b1111_1111_1111_1110,
                  {7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001});

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
